tile_rom_arbiter: RTL

Shares one synchronous tile ROM (address sampled on the falling edge of `vga_clk`, 4-bit palette index out) between several sprite/tile renderers. Each renderer posts a ROM address with a request. The block grants one requester per cycle in round-robin order, with optional lock-based bursts. It returns each ROM word to its owner with a per-requester valid strobe. It sits between the per-object renderers and the shared ROM instance, ahead of the palette lookup.

---
 rtl/tile_arb_pkg.sv | 9 +
 rtl/tile_rom_arbiter_rr_pick.sv | 34 +++
 rtl/tile_rom_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/tile_arb_pkg.sv
// Shared constants and types for the tile ROM arbiter and its round-robin picker.
package tile_arb_pkg;

    localparam int MAX_REQ     = 8;
    localparam int ROM_LATENCY = 2;

    typedef logic [2:0] owner_t;

endpackage

// File: rtl/tile_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping to 0.
module rr_pick
    import tile_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  owner_t           ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output owner_t           idx_o
);

    logic found;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        // Upper segment [ptr, N_REQ) has priority over the wrapped segment [0, ptr).
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i] && (owner_t'(i) >= ptr_i)) begin
                found = 1'b1;
                idx_o = owner_t'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i]) begin
                found = 1'b1;
                idx_o = owner_t'(i);
            end
        end
        gnt_o = found ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx_o) : '0;
    end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Round-robin arbiter with lock bursts sharing one tile ROM; returns each word
// to its owner two cycles after the grant.
module tile_rom_arbiter
    import tile_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
) (
    input  logic                    vga_clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rom_address,
    input  logic [DATA_W-1:0]       rom_q,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata
);

    owner_t              ptr_q, ptr_d;
    logic                locked_q, locked_d;
    logic [N_REQ-1:0]    own_mask, req_eff, pick_gnt;
    owner_t              pick_idx;
    logic                any_gnt, lock_sel;
    logic [ADDR_W-1:0]   addr_sel;

    logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
    logic                s1_valid_q, s1_valid_d;
    owner_t              s1_owner_q, s1_owner_d;
    logic [N_REQ-1:0]    rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // While locked the pointer sits on the owner; masking keeps everyone else out.
    always_comb begin
        own_mask = {{(N_REQ-1){1'b0}}, 1'b1} << ptr_q;
        req_eff  = (locked_q && |(req & own_mask)) ? own_mask : req;
    end

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i (req_eff),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    assign any_gnt = |pick_gnt;
    assign gnt     = reset_n ? pick_gnt : '0;

    always_comb begin
        lock_sel = |(lock & pick_gnt);
        addr_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) addr_sel = addr[i*ADDR_W +: ADDR_W];
        end

        ptr_d    = ptr_q;
        locked_d = any_gnt && lock_sel;
        if (any_gnt) begin
            if (lock_sel)                              ptr_d = pick_idx;
            else if (pick_idx == owner_t'(N_REQ - 1))  ptr_d = '0;
            else                                       ptr_d = pick_idx + owner_t'(1);
        end

        rom_address_d = any_gnt ? addr_sel : rom_address_q;
        s1_valid_d    = any_gnt;
        s1_owner_d    = any_gnt ? pick_idx : s1_owner_q;

        rvalid_d = s1_valid_q ? ({{(N_REQ-1){1'b0}}, 1'b1} << s1_owner_q) : '0;
        rdata_d  = s1_valid_q ? rom_q : rdata_q;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q         <= '0;
            locked_q      <= 1'b0;
            rom_address_q <= '0;
            s1_valid_q    <= 1'b0;
            s1_owner_q    <= '0;
            rvalid_q      <= '0;
            rdata_q       <= '0;
        end else begin
            ptr_q         <= ptr_d;
            locked_q      <= locked_d;
            rom_address_q <= rom_address_d;
            s1_valid_q    <= s1_valid_d;
            s1_owner_q    <= s1_owner_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
        end
    end

    assign rom_address = rom_address_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;

endmodule
